// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer regfile writer.
// Contents:
//   state_t       round FSM states
//   DATA_W/ADDR_W regfile data and address widths
//   EARLY_CODE    result written for a false start
//   TIMEOUT_CODE  result written when the player never reacts
//   LFSR_TAPS     tap mask for x^13+x^4+x^3+x+1
//   lfsr_next     one shift of the delay LFSR
package reaction_pkg;

  localparam int DATA_W = 13;
  localparam int ADDR_W = 3;

  localparam logic [DATA_W-1:0] EARLY_CODE   = 13'h0000;
  localparam logic [DATA_W-1:0] TIMEOUT_CODE = 13'h1FFF;
  // Bits 12, 3, 2 and 0 feed the XOR.
  localparam logic [DATA_W-1:0] LFSR_TAPS    = 13'h100D;

  typedef enum logic [1:0] {IDLE, WAIT, ARMED, WRITE} state_t;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler: divides CLK down to a one-cycle TICK pulse.
// Ports:
//   CLK   in  system clock
//   RST   in  asynchronous active-high reset
//   CLR   in  restart the count; the first TICK then follows TICKS_PER_MS
//             cycles later
//   TICK  out high for one cycle when the count reaches TICKS_PER_MS-1
module ms_prescaler #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

  logic [CW-1:0] cnt;

  assign TICK = (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR || TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_writer.sv
// Reaction-time round controller feeding the 8x13 register file write port.
// Each START (accepted only in IDLE) waits a pseudo-random number of ms,
// lights LED, counts ms until the player presses BUTTON, then writes the
// result into the next slot (round robin 0..7).
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   START      one-cycle pulse, begins a round when idle
//   BUTTON     synchronized player button (edge detected here)
//   LED        high while ARMED
//   BUSY       high whenever not IDLE
//   EARLY      sticky false-start flag, cleared by an accepted START
//   WA         write address (slot pointer)
//   LD_DATA    write data: ms, 0 = early, 1FFF = timeout
//   WR         write strobe, one cycle per round
//   dbg_state  current FSM state
//   BEST       fastest valid result since reset (only with BEST_TRACK_EN)
// Optional feature macro: BEST_TRACK_EN.
// Write handshake: WR is a one-cycle valid with no ready; the regfile
// always accepts, and WA/LD_DATA are stable for the whole WR cycle.
module reaction_timer_writer
  import reaction_pkg::*;
#(
  parameter int          TICKS_PER_MS = 50000,
  parameter int          DELAY_MIN_MS = 1000,
  parameter logic [9:0]  DELAY_MASK   = 10'h3FF,
  parameter logic [12:0] LFSR_SEED    = 13'h0001
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              BUTTON,
  output logic              LED,
  output logic              BUSY,
  output logic              EARLY,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] LD_DATA,
  output logic              WR,
  output logic [1:0]        dbg_state
`ifdef BEST_TRACK_EN
  ,
  output logic [DATA_W-1:0] BEST
`endif
);

  state_t              state, next_state;
  logic [DATA_W-1:0]   lfsr;
  logic                btn_q;
  logic                press;
  logic                tick;
  logic                clr;
  logic [DATA_W-1:0]   dly;
  logic [DATA_W-1:0]   ms;
  logic [ADDR_W-1:0]   slot;
  logic [DATA_W-1:0]   ld_data;
  logic                early;
  logic                load;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   dly_init;

  assign press    = BUTTON & ~btn_q;
  assign dly_init = DATA_W'(DELAY_MIN_MS) + {3'b000, lfsr[9:0] & DELAY_MASK};

  ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (clr),
    .TICK (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // A press always beats a tick in the same cycle, which gives both the
  // early-on-final-tick and the 1FFE-on-saturating-tick behaviour.
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    load       = 1'b0;
    wdata      = ld_data;
    case (state)
      IDLE: begin
        if (START) begin
          next_state = WAIT;
          clr        = 1'b1;
        end
      end
      WAIT: begin
        if (press) begin
          next_state = WRITE;
          load       = 1'b1;
          wdata      = EARLY_CODE;
        end else if (tick && dly == 13'd1) begin
          next_state = ARMED;
          clr        = 1'b1;
        end
      end
      ARMED: begin
        if (press) begin
          next_state = WRITE;
          load       = 1'b1;
          wdata      = ms;
        end else if (tick && ms == TIMEOUT_CODE - 13'd1) begin
          next_state = WRITE;
          load       = 1'b1;
          wdata      = TIMEOUT_CODE;
        end
      end
      WRITE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr    <= LFSR_SEED;
      btn_q   <= 1'b0;
      dly     <= '0;
      ms      <= '0;
      slot    <= '0;
      ld_data <= '0;
      early   <= 1'b0;
    end else begin
      btn_q <= BUTTON;
      // The LFSR only advances while idle, so START sees the value
      // from before this cycle's step.
      if (state == IDLE) lfsr <= lfsr_next(lfsr);
      if (state == IDLE && START)     dly <= dly_init;
      else if (state == WAIT && tick) dly <= dly - 13'd1;
      if (clr)                         ms <= '0;
      else if (state == ARMED && tick) ms <= ms + 13'd1;
      if (state == IDLE && START)       early <= 1'b0;
      else if (state == WAIT && press)  early <= 1'b1;
      if (load) ld_data <= wdata;
      if (state == WRITE) slot <= slot + 3'd1;
    end
  end

`ifdef BEST_TRACK_EN
  logic [DATA_W-1:0] best_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      best_q <= TIMEOUT_CODE;
    end else if (load && wdata != EARLY_CODE && wdata != TIMEOUT_CODE &&
                 wdata < best_q) begin
      best_q <= wdata;
    end
  end
  assign BEST = best_q;
`endif

  assign LED       = (state == ARMED);
  assign BUSY      = (state != IDLE);
  assign WR        = (state == WRITE);
  assign EARLY     = early;
  assign WA        = slot;
  assign LD_DATA   = ld_data;
  assign dbg_state = state;

endmodule

// File: tb/tb_reaction_timer_writer.sv
// Bench for reaction_timer_writer (TICKS_PER_MS=4, DELAY_MIN_MS=2,
// DELAY_MASK=3, seed 1). Round outcomes are computed arithmetically from
// the START edge, the chosen press edge and the LFSR sequence; expected
// writes go into a queue that a WR monitor pops. Build with BEST_TRACK_EN
// defined to also check BEST.
module tb_reaction_timer_writer;

  localparam int          T        = 4;
  localparam int          DMIN     = 2;
  localparam int          MASK     = 3;
  localparam logic [12:0] SEED     = 13'h0001;
  localparam int          TO_TICKS = 8191;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        button = 1'b0;
  logic        led, busy, early, wr;
  logic [2:0]  wa;
  logic [12:0] ld_data;
  logic [1:0]  dbg_state;
`ifdef BEST_TRACK_EN
  logic [12:0] best;
`endif

  reaction_timer_writer #(
    .TICKS_PER_MS (T),
    .DELAY_MIN_MS (DMIN),
    .DELAY_MASK   (10'h003),
    .LFSR_SEED    (SEED)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .BUTTON    (button),
    .LED       (led),
    .BUSY      (busy),
    .EARLY     (early),
    .WA        (wa),
    .LD_DATA   (ld_data),
    .WR        (wr),
    .dbg_state (dbg_state)
`ifdef BEST_TRACK_EN
    ,
    .BEST      (best)
`endif
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [47:0] exp_q[$];   // {wa, data, edge of WR}
  logic [47:0] mon_e;

  // reference-model state
  logic [12:0] m_lfsr;
  int          idle_from;
  logic [2:0]  slot_m;
  logic [12:0] best_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] lfsr_step(input logic [12:0] v);
    logic fb;
    fb = v[12] ^ v[3] ^ v[2] ^ v[0];
    return {v[11:0], fb};
  endfunction

  function automatic logic [12:0] lfsr_adv(input logic [12:0] v, input int n);
    logic [12:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = lfsr_step(r);
    return r;
  endfunction

  // WR monitor
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr: got WR with wa=%0d data=%0h, required no write (edge %0d)",
                 wa, ld_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_wa",   32'(wa),      32'(mon_e[47:45]));
        check("wr_data", 32'(ld_data), 32'(mon_e[44:32]));
        check("wr_edge", 32'(cyc),     mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    button = 1'b0;
    start = 1'b0;
    #1;
    check("rst_led_now",  32'(led),  0);
    check("rst_busy_now", 32'(busy), 0);
    check("rst_wr_now",   32'(wr),   0);
    next();
    next();
    rst = 1'b0;
    idle_from = cyc;
    m_lfsr = SEED;
    slot_m = 3'd0;
    best_m = 13'h1FFF;
    check("rst_early", 32'(early),     0);
    check("rst_wa",    32'(wa),        0);
    check("rst_data",  32'(ld_data),   0);
    check("rst_state", 32'(dbg_state), 0);
`ifdef BEST_TRACK_EN
    check("rst_best",  32'(best), 32'h1FFF);
`endif
  endtask

  // Issues an accepted START; returns its edge s and the ARMED entry edge a.
  task automatic begin_round(input int idle_wait, output int s, output int a);
    logic [12:0] pre;
    int dly;
    repeat (idle_wait) next();
    start = 1'b1;
    s = cyc + 1;
    pre = lfsr_adv(m_lfsr, s - 1 - idle_from);
    dly = DMIN + (int'(pre) & MASK);
    m_lfsr = lfsr_step(pre);
    a = s + T * dly;
    next();
    start = 1'b0;
    check("start_busy",  32'(busy),  1);
    check("start_early", 32'(early), 0);
  endtask

  // Presses at edge p (p < 0: never), checks LED/BUSY every cycle,
  // queues the expected write and updates the model.
  task automatic finish_round(input int s, input int a, input int p,
                              input bit hold, input bit extra);
    int w;
    logic [12:0] d;
    bit is_early;
    if (p < 0) begin
      w = a + T * TO_TICKS; d = 13'h1FFF; is_early = 1'b0;
    end else if (p <= a) begin
      w = p; d = 13'h0000; is_early = 1'b1;
    end else begin
      w = p; d = 13'((p - 1 - a) / T); is_early = 1'b0;
    end
    exp_q.push_back({slot_m, d, 32'(w)});
    while (cyc <= w) begin
      check("led",  32'(led),  32'(cyc >= a && cyc < w));
      check("busy", 32'(busy), 32'(cyc >= s));
      if (p >= 0 && cyc + 1 == p)          button = 1'b1;
      else if (p >= 0 && cyc + 1 == p - 1) button = 1'b0;
      start = extra ? ($urandom_range(0, 3) == 0) : 1'b0;
      next();
    end
    start = 1'b0;
    check("end_led",   32'(led),   0);
    check("end_busy",  32'(busy),  0);
    check("end_early", 32'(early), 32'(is_early));
    if (!hold) button = 1'b0;
    idle_from = cyc;
    slot_m = slot_m + 3'd1;
    if (!is_early && d != 13'h0 && d != 13'h1FFF && d < best_m) best_m = d;
`ifdef BEST_TRACK_EN
    check("best", 32'(best), 32'(best_m));
`endif
    if (s < 0) $display("note: bad round start %0d", s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, a;
    #2;
    do_reset();

    // first round straight after reset: 3 ms wait, 5 ms reaction
    begin_round(0, s, a);
    finish_round(s, a, a + 1 + T * 5 + $urandom_range(0, 3), 1'b0, 1'b0);

    // BEST sequence 7, 3, early, 9; then early on final tick and 0 ms
    do_reset();
    begin_round(0, s, a);
    finish_round(s, a, a + 1 + T * 7 + $urandom_range(0, 3), 1'b0, 1'b0);
    begin_round(1, s, a);
    finish_round(s, a, a + 1 + T * 3 + $urandom_range(0, 3), 1'b0, 1'b0);
    begin_round(2, s, a);
    finish_round(s, a, s + 2 + $urandom_range(0, a - s - 2), 1'b0, 1'b0);
    begin_round(0, s, a);
    finish_round(s, a, a + 1 + T * 9 + $urandom_range(0, 3), 1'b0, 1'b0);
    begin_round(1, s, a);
    finish_round(s, a, a, 1'b0, 1'b0);
    begin_round(0, s, a);
    finish_round(s, a, a + 1 + $urandom_range(0, 3), 1'b0, 1'b0);

    // nine valid rounds: slot wrap, stray STARTs, held button
    do_reset();
    for (int i = 0; i < 9; i++) begin
      begin_round($urandom_range(0, 4), s, a);
      finish_round(s, a, a + 1 + T * $urandom_range(0, 20) + $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b1);
    end

    // timeout: never pressed
    begin_round(2, s, a);
    finish_round(s, a, -1, 1'b0, 1'b1);

    // reset while ARMED aborts without a write; next round writes slot 0
    begin_round(0, s, a);
    while (cyc < a + 3) next();
    do_reset();
    begin_round(3, s, a);
    finish_round(s, a, a + 5, 1'b0, 1'b0);

    repeat (3) next();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "time limit");
  end

endmodule
